cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the L1 cache datapath/controller that operates on rv32i_cacheline (256-bit) transfers.
- Converts single-line read (fill) and write (writeback) requests into 4-beat, 64-bit burst transactions on the physical memory port.
- Returns a full line plus a one-cycle response to the cache.
- Owns line-aligned address generation, beat sequencing and data packing/unpacking.

Parameters:
- LINE_W, 256, cacheline width; must equal BEATS*BEAT_W.
- BEAT_W, 64, memory burst beat width.
- BEATS, 4, beats per line.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- address_i  in  32  byte address from cache (any offset).
- read_i  in  1  line fill request; held until resp_o.
- write_i  in  1  line writeback request; held until resp_o.
- line_i  in  256  writeback line data.
- line_o  out  256  assembled fill line; valid while resp_o=1.
- resp_o  out  1  one-cycle completion pulse to cache.
- address_o  out  32  line-aligned memory address.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- burst_o  out  64  write beat data.
- burst_i  in  64  read beat data.
- resp_i  in  1  memory beat acknowledge; one per beat.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, beat counter 0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0.
- Reset asserted mid-burst aborts the burst unconditionally. The next cycle is IDLE with no partial resp_o.
- FSM states: IDLE, READ, WRITE, DONE. All outputs are registered or decoded from registered state only; no combinational path from input to output.
- IDLE:
  - read_i=1 -> READ. Latch address_o={address_i[31:5],5'b0}; clear counter and line_o.
  - else write_i=1 -> WRITE. Latch address_o the same way and latch line_i.
  - Read has priority if both are high; write_i stays pending and is taken after the read's DONE.
  - resp_i is ignored in IDLE.
- READ: read_o=1.
  - Each cycle with resp_i=1 stores burst_i into line_o[BEAT_W*cnt +: BEAT_W], then cnt++.
  - Beat 0 is the low 64 bits.
  - Gaps (resp_i=0) are allowed and stall the counter.
  - On the 4th accepted beat -> DONE; read_o drops the same edge.
- WRITE: write_o=1, burst_o=line_q[BEAT_W*cnt +: BEAT_W].
  - cnt advances on each resp_i=1.
  - The 4th ack -> DONE.
- DONE:
  - resp_o=1 for exactly one cycle; line_o is held.
  - Next state is IDLE unconditionally. Requests are not sampled in DONE, so a requester dropping read_i/write_i on the resp_o cycle is safe.
- Counter: log2(BEATS)=2 bits; wraps to 0 on entry to DONE. No overflow is possible.
- Latency: request seen at edge 0 -> read_o/write_o from cycle 1. With zero-wait memory the beats arrive on cycles 1..4 and resp_o is on cycle 5.
- line_o keeps the last fill until the next READ entry or reset.
- Changes to address_i or line_i after acceptance have no effect.

Decomposition:
- Add to rv32i_types:
  - typedef rv32i_burst (logic [63:0]).
  - localparam CL_BEATS=4.
  - enum cla_state_t {IDLE, READ, WRITE, DONE}.
- Reuse rv32i_cacheline and rv32i_cache_offset width (5) for alignment.
- Single flat module; no sub-module is warranted.

Test Plan:
- Read, zero-wait:
  - Stimulus: read_i=1, address_i=0x0000_1234; beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on 4 consecutive resp_i cycles.
  - Required: address_o=0x0000_1220; resp_o high on cycle 5 only; line_o={0x4444…,0x3333…,0x2222…,0x1111…}.
- Read with gaps:
  - Stimulus: resp_i pattern 1,0,0,1,1,0,1.
  - Required: the same line assembled; resp_o exactly one cycle after the last ack; read_o deasserted on that ack edge.
- Write:
  - Stimulus: line_i=0xDDDD…_CCCC…_BBBB…_AAAA…, address_i=0x8000_003F.
  - Required: address_o=0x8000_0020; burst_o=0xAAAA… until the first ack, then BBBB, CCCC, DDDD; then one resp_o pulse.
- Simultaneous read_i and write_i:
  - Required: read burst completes first; write_o asserts the cycle after DONE→IDLE (write_i still held).
- Reset mid-read:
  - Stimulus: rst after 2 beats.
  - Required: next cycle read_o=0, resp_o=0, line_o=0; a fresh read afterwards completes normally with all 4 beats.
- Stray resp_i in IDLE:
  - Required: no state change and no resp_o.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared types and constants for the cacheline/burst adaptor.
//   rv32i_cacheline : one full cache line (256 bits)
//   rv32i_burst     : one memory burst beat (64 bits)
//   cla_state_t     : adaptor FSM states
package cacheline_adaptor_pkg;

    localparam int CL_LINE_W   = 256;
    localparam int CL_BEAT_W   = 64;
    localparam int CL_BEATS    = 4;
    localparam int CL_OFFSET_W = 5;

    typedef logic [CL_LINE_W-1:0] rv32i_cacheline;
    typedef logic [CL_BEAT_W-1:0] rv32i_burst;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } cla_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns single-line cache fills/writebacks into 4-beat 64-bit memory bursts.
//   Cache side : address_i, read_i, write_i, line_i in; line_o, resp_o out (resp_o is a 1-cycle pulse)
//   Memory side: address_o, read_o, write_o, burst_o out; burst_i, resp_i in (resp_i acks one beat)
//   All outputs come from registers or decode of registered state only.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_W = CL_LINE_W,
    parameter int BEAT_W = CL_BEAT_W,
    parameter int BEATS  = CL_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [BEAT_W-1:0] burst_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              resp_i
);

    localparam int CW = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    cla_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] fill_q, fill_d;
    logic              unused_offset;

    // The low offset bits never reach memory; the line is always fetched whole.
    assign unused_offset = ^address_i[CL_OFFSET_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                // Read wins a tie; a held write_i is picked up after the read completes.
                if (read_i) begin
                    state_d = READ;
                    addr_d  = {address_i[31:CL_OFFSET_W], {CL_OFFSET_W{1'b0}}};
                    cnt_d   = '0;
                    fill_d  = '0;
                end else if (write_i) begin
                    state_d = WRITE;
                    addr_d  = {address_i[31:CL_OFFSET_W], {CL_OFFSET_W{1'b0}}};
                    cnt_d   = '0;
                    wline_d = line_i;
                end
            end
            READ: begin
                if (resp_i) begin
                    fill_d[BEAT_W*cnt_q +: BEAT_W] = burst_i;
                    cnt_d = cnt_q + CW'(1);
                    state_d = (cnt_q == LAST) ? DONE : READ;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CW'(1);
                    state_d = (cnt_q == LAST) ? DONE : WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);
    assign address_o = addr_q;
    assign line_o    = fill_q;
    assign burst_o   = (state_q == WRITE) ? wline_q[BEAT_W*cnt_q +: BEAT_W] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: scoreboard bench with a randomized memory responder and a line-level reference model.
`timescale 1ns/1ps
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    bit           fixed = 0;
    bit           stray = 0;
    bit           use_pat = 0;
    int           gap_pct = 0;
    logic [6:0]   pat = 7'b1011001;
    int           beat_idx = 0;
    int           pidx = 0;
    logic [255:0] wr_line = '0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory contents as seen by the bench: beat k of the line at address a.
    function automatic logic [63:0] bd(input logic [31:0] a, input int k);
        return fixed ? {16{4'(k + 1)}} : {~a ^ (32'(k) * 32'h0101_0101), a + 32'(k)};
    endfunction

    function automatic logic [255:0] model_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = bd(a, k);
        return l;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            beat_idx <= 0;
            pidx     <= 0;
        end else if (read_o || write_o) begin
            pidx <= pidx + 1;
            if (resp_i) beat_idx <= (beat_idx == 3) ? 0 : beat_idx + 1;
        end else begin
            pidx <= 0;
        end
    end

    always @(negedge clk) begin
        if (stray) resp_i = 1'b1;
        else if (!(read_o || write_o)) resp_i = 1'b0;
        else if (use_pat) resp_i = (pidx < 7) ? pat[pidx] : 1'b1;
        else resp_i = ($urandom_range(99) >= gap_pct);
        burst_i = bd(address_o, beat_idx);
        if (write_o && pidx == 0) wr_line = '0;
        if (write_o && resp_i) wr_line[64*beat_idx +: 64] = burst_o;
    end

    always @(negedge clk) begin
        if (!rst && resp_o) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 256'(resp_o), 256'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_addr", 256'(address_o), 256'(e.addr));
                check("resp_mem_idle", 256'({read_o, write_o}), 256'(0));
                if (e.wr) check("write_line", wr_line, e.line);
                else check("read_line", line_o, model_line(e.addr));
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [255:0] line);
        exp_t e;
        @(negedge clk);
        read_i    = !wr;
        write_i   = wr;
        address_i = addr;
        line_i    = line;
        e.wr   = wr;
        e.addr = addr & ~32'h1F;
        e.line = line;
        sb.push_back(e);
    endtask

    task automatic wait_resp(output int cyc, input bit keep_wr);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !keep_wr) begin
                address_i = $urandom;
                line_i    = {8{$urandom}};
            end
        end while (!resp_o && cyc < 200);
        if (!resp_o) check("resp_timeout", 256'(resp_o), 256'(1));
        read_i = 1'b0;
        if (!keep_wr) write_i = 1'b0;
    endtask

    task automatic req(input bit wr, input logic [31:0] addr, input logic [255:0] line, input int exp_lat);
        int c;
        issue(wr, addr, line);
        wait_resp(c, 1'b0);
        if (exp_lat > 0) check("latency", 256'(c), 256'(exp_lat));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        exp_t e;
        rst = 1'b1;
        read_i = 1'b0;
        write_i = 1'b0;
        address_i = 32'hFFFF_FFFF;
        line_i = '1;
        resp_i = 1'b0;
        burst_i = '0;
        repeat (3) @(negedge clk);
        check("rst_read_o", 256'(read_o), 256'(0));
        check("rst_write_o", 256'(write_o), 256'(0));
        check("rst_resp_o", 256'(resp_o), 256'(0));
        check("rst_address_o", 256'(address_o), 256'(0));
        check("rst_burst_o", 256'(burst_o), 256'(0));
        check("rst_line_o", line_o, 256'(0));
        rst = 1'b0;

        stray = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stray_idle", 256'({read_o, write_o, resp_o}), 256'(0));
        end
        stray = 1'b0;

        fixed = 1'b1;
        gap_pct = 0;
        req(1'b0, 32'h0000_1234, '0, 5);
        use_pat = 1'b1;
        req(1'b0, 32'h0000_5678, '0, 8);
        use_pat = 1'b0;
        req(1'b1, 32'h8000_003F, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 5);
        check("line_o_held_after_write", line_o, model_line(32'h0000_5660));
        fixed = 1'b0;

        @(negedge clk);
        read_i = 1'b1;
        write_i = 1'b1;
        address_i = 32'h0000_0107;
        line_i = {8{$urandom}};
        e.wr = 1'b0; e.addr = 32'h0000_0100; e.line = line_i;
        sb.push_back(e);
        e.wr = 1'b1;
        sb.push_back(e);
        wait_resp(c, 1'b1);
        @(negedge clk);
        check("sim_idle_gap", 256'(write_o), 256'(0));
        @(negedge clk);
        check("sim_write_start", 256'(write_o), 256'(1));
        wait_resp(c, 1'b0);

        issue(1'b0, 32'h0000_4444, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        read_i = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_read_o", 256'(read_o), 256'(0));
        check("abort_resp_o", 256'(resp_o), 256'(0));
        check("abort_line_o", line_o, 256'(0));
        rst = 1'b0;
        req(1'b0, 32'h0000_4444, '0, 5);

        gap_pct = 35;
        repeat (40) req(1'($urandom_range(1)), $urandom, {8{$urandom}}, 0);

        repeat (5) @(negedge clk);
        check("sb_drained", 256'(sb.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
